// File: rtl/full_adder_4bit_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the registered ripple-carry adder slice.
//   ADDER_DEFAULT_WIDTH : default operand/sum width
//   adder_result_t      : {cout, sum} result record at the default width
// Optional feature macro used elsewhere in this slice: FULL_ADDER_4BIT_OVF_EN
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam int ADDER_DEFAULT_WIDTH = 4;

    typedef struct packed {
        logic                           cout;
        logic [ADDER_DEFAULT_WIDTH-1:0] sum;
    } adder_result_t;

endpackage : adder_pkg

// File: rtl/full_adder_4bit_if.sv
// -----------------------------------------------------------------------------
// full_adder_4bit_if
// Operand / result bundle for full_adder_4bit.
//   in_valid, A, B, Cin : operands, driven by the master
//   Sum, Cout, out_valid: registered result, driven by the slave (the adder)
//   Ovf                 : signed overflow, present only when
//                         FULL_ADDER_4BIT_OVF_EN is defined
// -----------------------------------------------------------------------------
interface full_adder_4bit_if
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_DEFAULT_WIDTH
);
    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             out_valid;
`ifdef FULL_ADDER_4BIT_OVF_EN
    logic             Ovf;
`endif

`ifdef FULL_ADDER_4BIT_OVF_EN
    modport master (output in_valid, A, B, Cin, input Sum, Cout, out_valid, Ovf);
    modport slave  (input in_valid, A, B, Cin, output Sum, Cout, out_valid, Ovf);
`else
    modport master (output in_valid, A, B, Cin, input Sum, Cout, out_valid);
    modport slave  (input in_valid, A, B, Cin, output Sum, Cout, out_valid);
`endif

endinterface : full_adder_4bit_if

// File: rtl/full_adder_4bit_cell.sv
// -----------------------------------------------------------------------------
// full_adder_1bit
// One combinational full-adder cell.
//   a, b : operand bits
//   cin  : carry in
//   s    : sum bit
//   cout : carry out
// -----------------------------------------------------------------------------
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule : full_adder_1bit

// File: rtl/full_adder_4bit.sv
// -----------------------------------------------------------------------------
// full_adder_4bit
// Registered ripple-carry adder: {Cout, Sum} = A + B + Cin, one cycle after
// the operands are sampled with in_valid. Result holds while in_valid is low;
// out_valid marks the single cycle carrying a new result.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears result and out_valid
//   bus   : full_adder_4bit_if.slave (operands in, registered result out)
// Optional: FULL_ADDER_4BIT_OVF_EN adds a registered signed-overflow flag Ovf.
// -----------------------------------------------------------------------------
module full_adder_4bit
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    full_adder_4bit_if.slave   bus
);
    // carry[i] is the carry into cell i; carry[WIDTH] is the final carry-out
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_c;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             valid_q;

    assign carry[0] = bus.Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_1bit u_cell (
            .a    (bus.A[i]),
            .b    (bus.B[i]),
            .cin  (carry[i]),
            .s    (sum_c[i]),
            .cout (carry[i+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                sum_q  <= sum_c;
                cout_q <= carry[WIDTH];
            end
        end
    end

    assign bus.Sum       = sum_q;
    assign bus.Cout      = cout_q;
    assign bus.out_valid = valid_q;

`ifdef FULL_ADDER_4BIT_OVF_EN
    // Signed overflow: carry into the MSB cell disagrees with carry out of it
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (bus.in_valid) begin
            ovf_q <= carry[WIDTH-1] ^ carry[WIDTH];
        end
    end

    assign bus.Ovf = ovf_q;
`endif

endmodule : full_adder_4bit

// File: tb/tb_full_adder_4bit.sv
// -----------------------------------------------------------------------------
// tb_full_adder_4bit
// Self-checking bench for full_adder_4bit (WIDTH = 4): directed vector table,
// reset / hold / async-reset sequences, exhaustive and random sweeps against
// an arithmetic reference model.
// Honours FULL_ADDER_4BIT_OVF_EN when defined.
// -----------------------------------------------------------------------------
module tb_full_adder_4bit;
    import adder_pkg::*;

    localparam int W = ADDER_DEFAULT_WIDTH;

    logic clk;
    logic rst_n;

    full_adder_4bit_if #(.WIDTH(W)) bus ();

    full_adder_4bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: what the outputs should show right now
    int   m_sum;
    int   m_cout;
    int   m_ovf;
    int   m_valid;

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          cin;
        adder_result_t res;
        logic          ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sum = 0; m_cout = 0; m_ovf = 0; m_valid = 0;
    endtask

    // Arithmetic reference: unsigned total for sum/cout, signed total for ovf
    task automatic model_edge(input logic v, input int a, input int b, input int cin);
        int total;
        int sa;
        int sb;
        int stot;
        m_valid = v;
        if (v) begin
            total  = a + b + cin;
            m_sum  = total % (1 << W);
            m_cout = (total >= (1 << W)) ? 1 : 0;
            sa     = (a >= (1 << (W-1))) ? a - (1 << W) : a;
            sb     = (b >= (1 << (W-1))) ? b - (1 << W) : b;
            stot   = sa + sb + cin;
            m_ovf  = (stot > (1 << (W-1)) - 1 || stot < -(1 << (W-1))) ? 1 : 0;
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".sum"},   int'(bus.Sum),       m_sum);
        chk({tag, ".cout"},  int'(bus.Cout),      m_cout);
        chk({tag, ".valid"}, int'(bus.out_valid), m_valid);
`ifdef FULL_ADDER_4BIT_OVF_EN
        chk({tag, ".ovf"},   int'(bus.Ovf),       m_ovf);
`endif
    endtask

    task automatic drive_edge(input logic v, input int a, input int b, input int cin);
        @(negedge clk);
        bus.in_valid = v;
        bus.A        = W'(a);
        bus.B        = W'(b);
        bus.Cin      = cin[0];
        @(posedge clk);
        #1;
        model_edge(v, a, b, cin);
    endtask

    task automatic step(input string tag, input logic v, input int a, input int b, input int cin);
        drive_edge(v, a, b, cin);
        chk_model(tag);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".sum"},   int'(bus.Sum),       0);
        chk({tag, ".cout"},  int'(bus.Cout),      0);
        chk({tag, ".valid"}, int'(bus.out_valid), 0);
`ifdef FULL_ADDER_4BIT_OVF_EN
        chk({tag, ".ovf"},   int'(bus.Ovf),       0);
`endif
    endtask

    initial begin
        // a, b, cin, {cout, sum}, ovf -- hand-computed
        vecs[0] = '{4'd5,  4'd3,  1'b0, '{1'b0, 4'd8},  1'b1};
        vecs[1] = '{4'd2,  4'd4,  1'b1, '{1'b0, 4'd7},  1'b0};
        vecs[2] = '{4'd6,  4'd8,  1'b1, '{1'b0, 4'd15}, 1'b0};
        vecs[3] = '{4'd2,  4'd1,  1'b1, '{1'b0, 4'd4},  1'b0};
        vecs[4] = '{4'd9,  4'd7,  1'b1, '{1'b1, 4'd1},  1'b0};
        vecs[5] = '{4'd15, 4'd15, 1'b1, '{1'b1, 4'd15}, 1'b0};
        vecs[6] = '{4'd7,  4'd1,  1'b0, '{1'b0, 4'd8},  1'b1};
        vecs[7] = '{4'd0,  4'd0,  1'b0, '{1'b0, 4'd0},  1'b0};

        // Reset held over three edges with live operands
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.A        = 4'd9;
        bus.B        = 4'd7;
        bus.Cin      = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk_zero("reset");
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;

        // Directed table, back-to-back
        for (int i = 0; i < 8; i++) begin
            drive_edge(1'b1, int'(vecs[i].a), int'(vecs[i].b), int'(vecs[i].cin));
            chk("dir.sum",   int'(bus.Sum),       int'(vecs[i].res.sum));
            chk("dir.cout",  int'(bus.Cout),      int'(vecs[i].res.cout));
            chk("dir.valid", int'(bus.out_valid), 1);
`ifdef FULL_ADDER_4BIT_OVF_EN
            chk("dir.ovf",   int'(bus.Ovf),       int'(vecs[i].ovf));
`endif
        end

        // Hold: result stays after in_valid drops and operands change
        step("hold.load", 1'b1, 5, 3, 0);
        drive_edge(1'b0, 15, 15, 1);
        chk("hold.sum",   int'(bus.Sum),       8);
        chk("hold.cout",  int'(bus.Cout),      0);
        chk("hold.valid", int'(bus.out_valid), 0);
        step("hold.idle", 1'b0, 15, 15, 1);

        // Asynchronous reset pulse between edges while operands are valid
        step("areset.pre", 1'b1, 9, 7, 1);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.A        = 4'd6;
        bus.B        = 4'd3;
        bus.Cin      = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("areset.async");
        model_reset();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_edge(1'b1, 6, 3, 0);
        chk_model("areset.first");
        chk("areset.first_sum", int'(bus.Sum), 9);

        // Exhaustive, back-to-back
        for (int c = 0; c < 2; c++)
            for (int a = 0; a < 16; a++)
                for (int b = 0; b < 16; b++)
                    step("exh", 1'b1, a, b, c);

        // Random operands with random gaps
        for (int i = 0; i < 300; i++)
            step("rand", ($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_full_adder_4bit

// File: doc/full_adder_4bit.md
Name: full_adder_4bit

Overview:
Registered ripple-carry adder. Computes A + B + Cin and presents {Cout, Sum} one clock after the operands are sampled. Used as a small arithmetic leaf in datapaths that need a clean registered sum and a valid strobe. Width is parameterised; the default is 4 bits.

Parameters:
WIDTH, 4, operand and sum width in bits; legal range is 1 or more.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous reset, active-low
in_valid  input  1  operands valid this cycle; sample A, B and Cin
A  input  WIDTH  operand A, unsigned
B  input  WIDTH  operand B, unsigned
Cin  input  1  carry-in
Sum  output  WIDTH  registered sum bits [WIDTH-1:0]
Cout  output  1  registered carry-out; bit WIDTH of the full result
out_valid  output  1  Sum and Cout hold a new result this cycle

Behaviour:
- Reset: rst_n low asynchronously forces Sum = 0, Cout = 0 and out_valid = 0. The state stays cleared while rst_n is low. Release is synchronous to the next rising clk edge.
- Datapath: combinational ripple of WIDTH 1-bit full-adder cells.
  - Cell i computes s = a ^ b ^ c and co = (a & b) | (c & (a ^ b)).
  - Cell 0 takes Cin as its carry-in. The carry-out of the top cell is Cout.
- Arithmetic: {Cout, Sum} = A + B + Cin, exactly WIDTH+1 bits. There is no saturation; the sum wraps modulo 2^WIDTH and the excess goes to Cout.
- Latency: exactly 1 cycle.
  - in_valid high at edge k loads Sum and Cout from that edge's operands.
  - out_valid is high for the cycle following edge k.
- Hold: with in_valid low, Sum and Cout keep their last value and out_valid drops to 0 on the next edge.
- Throughput: one operation per cycle. Back-to-back in_valid gives a new result every cycle with out_valid continuously high.
- No backpressure: the downstream must accept the result in the out_valid cycle.
- Boundary cases:
  - All-ones A and B with Cin=1 gives Sum all-ones and Cout=1.
  - All zeros with Cin=0 gives Sum=0, Cout=0, and out_valid is still asserted.
- Reset mid-operation: the in-flight result is discarded. out_valid is 0 after reset even if in_valid was high at the edge reset asserted.
- X-free: reset defines every output; no latches.

Optional Feature:
Macro FULL_ADDER_4BIT_OVF_EN.
- Defined:
  - Adds output port Ovf (1 bit), registered alongside Sum.
  - Ovf = carry into the MSB cell XOR carry out of the MSB cell, i.e. signed two's-complement overflow.
  - Ovf resets to 0, holds when in_valid is low, and has the same latency as Sum.
- Not defined: the Ovf port and its logic do not exist. All other behaviour is identical.

Decomposition:
- Shared package adder_pkg holds:
  - localparam ADDER_DEFAULT_WIDTH = 4;
  - a result struct typedef {logic cout; logic [WIDTH-1:0] sum;} for the default width.
- One sub-module, full_adder_1bit, with ports a, b, cin, s, cout (purely combinational).
  - The top instantiates WIDTH copies in a generate loop and chains the carries.
  - The output registers live in the top.

Test Plan:
1. Reset: hold rst_n=0 over 3 edges with in_valid=1, A=9, B=7 -> Sum=0, Cout=0, out_valid=0 throughout.
2. Directed sums, one per cycle, in_valid=1; each result appears 1 cycle later with out_valid=1:
   - A=5, B=3, Cin=0 -> Sum=8, Cout=0
   - A=2, B=4, Cin=1 -> Sum=7, Cout=0
   - A=6, B=8, Cin=1 -> Sum=15, Cout=0
   - A=2, B=1, Cin=1 -> Sum=4, Cout=0
3. Wrap-around: A=9, B=7, Cin=1 -> Sum=1, Cout=1. A=15, B=15, Cin=1 -> Sum=15, Cout=1. With OVF_EN, A=7, B=1, Cin=0 -> Ovf=1.
4. Hold: after A=5, B=3 is sampled, drop in_valid and change A and B to 15 -> Sum stays 8, out_valid is 0 from the next cycle.
5. Async reset mid-stream: pulse rst_n low between edges while in_valid=1 -> Sum, Cout and out_valid go to 0 immediately, without waiting for an edge, and the first post-reset result appears 1 cycle after in_valid is sampled.
6. Exhaustive: all 512 combinations of A, B and Cin, back-to-back -> every {Cout, Sum} equals A+B+Cin, with out_valid continuously 1.
